seq_det_sched: RTL and testbench

//  Shares one bit-serial pattern-match engine among NCH serial input channels.

---
 rtl/seq_det_sched.sv | 172 +++++++++++++++++
 tb/tb_seq_det_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// Round-robin shared bit-serial pattern detector for NCH serial channels.
// Optional per-channel saturating match counters are built when SEQ_DET_CNT_EN is defined.
module seq_det_sched #(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011,
    parameter int              CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     ovl,
    input  logic [NCH-1:0]           ch_valid,
    input  logic [NCH-1:0]           ch_bit,
    input  logic [NCH-1:0]           ch_flush,
    output logic [NCH-1:0]           ch_ready,
    output logic                     match_valid,
    output logic [$clog2(NCH)-1:0]   match_ch,
    input  logic [$clog2(NCH)-1:0]   cnt_sel,
    output logic [CNT_W-1:0]         cnt_out
);

    localparam int CH_W   = $clog2(NCH);
    localparam int FILL_W = $clog2(PLEN + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PLEN);
    localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PLEN - 1);

    function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
        sat_fill = (f >= FILL_MAX) ? FILL_MAX : f + FILL_W'(1'b1);
    endfunction

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [PLEN-1:0]   hist_q [NCH];
    logic [PLEN-1:0]   hist_d [NCH];
    logic [FILL_W-1:0] fill_q [NCH];
    logic [FILL_W-1:0] fill_d [NCH];
    logic              match_valid_q, match_valid_d;
    logic [CH_W-1:0]   match_ch_q, match_ch_d;

    logic [NCH-1:0]    cand_s;
    logic [CH_W-1:0]   scan_ch_s;
    logic              take_s;
    logic              grant_found_s;
    logic [CH_W-1:0]   grant_s;
    logic              arb_on_s;
    logic              grant_v_s;
    logic [PLEN-1:0]   new_hist_s;
    logic              hit_s;

    // Rotating-priority search starting at ptr; a flushed channel is never a candidate.
    always_comb begin
        cand_s        = ch_valid & ~ch_flush;
        scan_ch_s     = {CH_W{1'b0}};
        take_s        = 1'b0;
        grant_found_s = 1'b0;
        grant_s       = {CH_W{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            scan_ch_s     = CH_W'((int'(ptr_q) + k) % NCH);
            take_s        = cand_s[scan_ch_s] & ~grant_found_s;
            grant_s       = take_s ? scan_ch_s : grant_s;
            grant_found_s = grant_found_s | take_s;
        end
    end

    // Grant qualification, engine datapath and hit detection for the granted channel.
    always_comb begin
        arb_on_s   = (state_q == ST_RUN) & en & ~rst;
        grant_v_s  = arb_on_s & grant_found_s;
        ch_ready   = grant_v_s ? ({{(NCH-1){1'b0}}, 1'b1} << grant_s) : {NCH{1'b0}};
        new_hist_s = {hist_q[grant_s][PLEN-2:0], ch_bit[grant_s]};
        hit_s      = grant_v_s & (fill_q[grant_s] >= FILL_HIT) & (new_hist_s == PATTERN);
    end

    // Next-state for FSM, pointer, per-channel context and match report.
    always_comb begin
        case (state_q)
            ST_IDLE: state_d = en ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = en ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (grant_v_s) begin
            ptr_d = (grant_s == CH_W'(NCH - 1)) ? {CH_W{1'b0}} : grant_s + CH_W'(1'b1);
        end else begin
            ptr_d = ptr_q;
        end
        for (int i = 0; i < NCH; i++) begin
            // Flush is an explicit clear request and acts even while en is low.
            if (ch_flush[i]) begin
                hist_d[i] = {PLEN{1'b0}};
                fill_d[i] = {FILL_W{1'b0}};
            end else if (grant_v_s && (grant_s == CH_W'(i))) begin
                if (hit_s && !ovl) begin
                    hist_d[i] = {PLEN{1'b0}};
                    fill_d[i] = {FILL_W{1'b0}};
                end else begin
                    hist_d[i] = new_hist_s;
                    fill_d[i] = sat_fill(fill_q[i]);
                end
            end else begin
                hist_d[i] = hist_q[i];
                fill_d[i] = fill_q[i];
            end
        end
        match_valid_d = hit_s;
        match_ch_d    = hit_s ? grant_s : match_ch_q;
    end

    // Context and report registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= {CH_W{1'b0}};
            match_valid_q <= 1'b0;
            match_ch_q    <= {CH_W{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= {PLEN{1'b0}};
                fill_q[i] <= {FILL_W{1'b0}};
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= hist_d[i];
                fill_q[i] <= fill_d[i];
            end
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    // Saturating per-channel hit counters, cleared by flush.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (ch_flush[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (hit_s && (grant_s == CH_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1'b1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt_out = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : {CNT_W{1'b0}};
`else
    logic unused_cnt_sel_s;
    assign unused_cnt_sel_s = ^cnt_sel;
    assign cnt_out          = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: directed streams push expected matches,
// a negedge monitor pops and compares channel and arrival cycle.
module tb_seq_det_sched;
    localparam int NCH   = 4;
    localparam int CNT_W = 2;
`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, en, ovl;
    logic [NCH-1:0]   ch_valid, ch_bit, ch_flush, ch_ready;
    logic             match_valid;
    logic [1:0]       match_ch, cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    seq_det_sched #(.NCH(NCH), .PLEN(4), .PATTERN(4'b1011), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .ovl(ovl),
        .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_flush(ch_flush), .ch_ready(ch_ready),
        .match_valid(match_valid), .match_ch(match_ch),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { int ch; int cyc; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every match pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (match_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_match: got match on ch %0d at cycle %0d, expected none", match_ch, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("match_ch", int'(match_ch), mon_e.ch);
                check("match_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] f,
                         input logic [3:0] exp_rdy, input int hit_ch, input string name);
        ch_valid = v;
        ch_bit   = b;
        ch_flush = f;
        #1;
        check({name, "_ready"}, int'(ch_ready), int'(exp_rdy));
        if (hit_ch >= 0) exp_q.push_back('{hit_ch, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [6:0]  s1;
        logic [3:0]  pat;
        logic [15:0] s6;
        logic        bt;
        int          nh;
        s1  = 7'b1011011;
        pat = 4'b1011;
        s6  = 16'b1011011011011011;

        rst = 1'b1; en = 1'b1; ovl = 1'b1; cnt_sel = 2'd1;
        ch_valid = 4'b1111; ch_bit = 4'b1111; ch_flush = 4'b0000;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", int'(ch_ready), 0);
        check("rst_match_valid", int'(match_valid), 0);
        check("rst_match_ch", int'(match_ch), 0);
        check("rst_cnt_out", int'(cnt_out), 0);
        rst = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, "idle");

        // Overlapping detection on ch0.
        for (int i = 0; i < 7; i++) begin
            bt = s1[6-i];
            drive(4'b0001, {3'b000, bt}, 4'b0000, 4'b0001, (i == 3 || i == 6) ? 0 : -1, "t1");
        end
        drive(4'b0000, 4'b0000, 4'b0001, 4'b0000, -1, "t1_flush");
        check("t1_pending", exp_q.size(), 0);

        // Non-overlapping: history cleared after a hit.
        ovl = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bt = s1[6-i];
            drive(4'b0001, {3'b000, bt}, 4'b0000, 4'b0001, (i == 3) ? 0 : -1, "t2");
        end
        drive(4'b0000, 4'b0000, 4'b0001, 4'b0000, -1, "t2_flush");
        check("t2_pending", exp_q.size(), 0);
        ovl = 1'b1;

        // Flush beats grant; fill restarts.
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, -1, "t4");
        drive(4'b0100, 4'b0000, 4'b0000, 4'b0100, -1, "t4");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, -1, "t4");
        drive(4'b0100, 4'b0100, 4'b0100, 4'b0000, -1, "t4_flushgrant");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, -1, "t4_after");
        drive(4'b0100, 4'b0000, 4'b0000, 4'b0100, -1, "t4_after");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, -1, "t4_after");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100,  2, "t4_after");
        drive(4'b0000, 4'b0000, 4'b0100, 4'b0000, -1, "t4_flush");
        check("t4_pending", exp_q.size(), 0);

        // en falling right after a hit: pending match still fires, no grant.
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, "ef");
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, -1, "ef");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, "ef");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001,  0, "ef");
        en = 1'b0;
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, -1, "ef_en0");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, -1, "ef_en0");
        en = 1'b1;
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, -1, "ef_idle");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, "ef_run");
        check("ef_pending", exp_q.size(), 0);

        // Round robin from reset; only ch1 is fed the pattern.
        rst = 1'b1;
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, -1, "t3_rst");
        rst = 1'b0;
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, -1, "t3_idle");
        for (int k = 0; k < 16; k++) begin
            bt = pat[3 - k/4];
            drive(4'b1111, {2'b11, bt, 1'b1}, 4'b0000, 4'b0001 << (k % 4), (k == 13) ? 1 : -1, "t3");
        end
        drive(4'b0000, 4'b0000, 4'b1111, 4'b0000, -1, "t3_flush");
        check("t3_pending", exp_q.size(), 0);

        // Counter readback on ch1 across five hits.
        nh = 0;
        for (int i = 0; i < 16; i++) begin
            bt = s6[15-i];
            drive(4'b0010, {2'b00, bt, 1'b0}, 4'b0000, 4'b0010,
                  (i >= 3 && i % 3 == 0) ? 1 : -1, "t6");
            if (i >= 3 && i % 3 == 0) begin
                nh++;
                check("t6_cnt_out", int'(cnt_out), CNT_EN ? ((nh > 3) ? 3 : nh) : 0);
            end
        end
        drive(4'b0000, 4'b0000, 4'b0010, 4'b0000, -1, "t6_flush");
        check("t6_cnt_cleared", int'(cnt_out), 0);
        check("t6_pending", exp_q.size(), 0);

        // Reset in the cycle a hit would be consumed.
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, "t5");
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, -1, "t5");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, "t5");
        rst = 1'b1;
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, -1, "t5_rst");
        check("t5_match_suppressed", int'(match_valid), 0);
        rst = 1'b0;
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, -1, "t5_idle");
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0001, -1, "t5_ptr0");
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, "t5_end");
        check("t5_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
